mpu_hm_responder: RTL and testbench

Responder end of the MPU host memory bus. Accepts 64-bit read requests from the MPU, fetches the aligned doubleword from system memory as two 32-bit Wishbone master read beats, and returns it on hm_data. Holds a single-entry doubleword buffer so repeated reads of the same address complete without bus traffic. Sits between the MPU core and the system Wishbone interconnect, on the same clock as the MPU.

---
 rtl/mpu_hm_responder.sv | 163 ++++++++++++++++
 tb/tb_mpu_hm_responder.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mpu_hm_responder.sv
// MPU host-memory responder: serves 64-bit reads from system memory as two
// 32-bit Wishbone read beats, with a single-entry doubleword hit buffer.
module mpu_hm_responder #(
   parameter int unsigned TIMEOUT = 255,  // per-beat ack wait limit, 1..255
   parameter bit          BUF_EN  = 1'b1  // 1 = hit buffer enabled
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic        hm_stb,
   input  logic [63:0] hm_addr,
   output logic [63:0] hm_data,
   output logic        hm_ack,
   output logic        hm_err,
   input  logic        flush,
   output logic [31:0] wbm_adr_o,
   input  logic [31:0] wbm_dat_i,
   output logic [3:0]  wbm_sel_o,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   output logic        wbm_we_o,
   input  logic        wbm_ack_i,
   input  logic        wbm_err_i
);

   typedef enum logic [1:0] {StIdle, StRdLo, StRdHi, StResp} state_t;

   localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

   state_t      r_state;
   logic [63:0] r_hm_data;
   logic        r_hm_ack;
   logic        r_hm_err;
   logic [31:0] r_adr;
   logic        r_cyc;
   logic [7:0]  r_cnt;
   logic [63:0] r_fetch;       // data staged for the next response
   logic        r_err;         // pending response is an error
   logic [28:0] r_req_tag;     // tag of the in-flight fetch
   logic        r_flush_pend;  // flush seen during the in-flight fetch
   logic        r_buf_valid;
   logic [28:0] r_buf_tag;
   logic [63:0] r_buf_data;

   logic        w_high;
   logic        w_hit;
   logic [7:0]  w_cnt_inc;
   logic        w_timeout;
   logic        w_unused_addr;

   // Request decode and per-beat timeout detection
   always_comb begin
      w_high        = |hm_addr[63:32];
      // A flush in the same cycle already invalidates the entry.
      w_hit         = BUF_EN && r_buf_valid && !flush && (hm_addr[31:3] == r_buf_tag);
      w_cnt_inc     = r_cnt + 8'd1;
      w_timeout     = (w_cnt_inc == TimeoutCnt);
      w_unused_addr = ^hm_addr[2:0];
   end

   // Responder FSM with registered host and Wishbone outputs plus hit buffer
   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         r_state      <= StIdle;
         r_hm_data    <= '0;
         r_hm_ack     <= 1'b0;
         r_hm_err     <= 1'b0;
         r_adr        <= '0;
         r_cyc        <= 1'b0;
         r_cnt        <= '0;
         r_fetch      <= '0;
         r_err        <= 1'b0;
         r_req_tag    <= '0;
         r_flush_pend <= 1'b0;
         r_buf_valid  <= 1'b0;
         r_buf_tag    <= '0;
         r_buf_data   <= '0;
      end else begin
         r_hm_ack <= 1'b0;
         r_hm_err <= 1'b0;
         if (flush) begin
            r_buf_valid <= 1'b0;
         end
         unique case (r_state)
            StIdle: begin
               if (hm_stb) begin
                  if (w_high) begin
                     r_err   <= 1'b1;
                     r_state <= StResp;
                  end else if (w_hit) begin
                     r_err   <= 1'b0;
                     r_fetch <= r_buf_data;
                     r_state <= StResp;
                  end else begin
                     r_err        <= 1'b0;
                     r_req_tag    <= hm_addr[31:3];
                     r_adr        <= {hm_addr[31:3], 3'b000};
                     r_cyc        <= 1'b1;
                     r_cnt        <= '0;
                     r_flush_pend <= 1'b0;
                     r_state      <= StRdLo;
                  end
               end
            end
            StRdLo: begin
               if (flush) begin
                  r_flush_pend <= 1'b1;
               end
               if (wbm_err_i || (!wbm_ack_i && w_timeout)) begin
                  r_cyc   <= 1'b0;
                  r_err   <= 1'b1;
                  r_state <= StResp;
               end else if (wbm_ack_i) begin
                  r_fetch[31:0] <= wbm_dat_i;
                  r_adr         <= {r_adr[31:3], 3'b100};
                  r_cnt         <= '0;
                  r_state       <= StRdHi;
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end
            StRdHi: begin
               if (flush) begin
                  r_flush_pend <= 1'b1;
               end
               if (wbm_err_i || (!wbm_ack_i && w_timeout)) begin
                  r_cyc   <= 1'b0;
                  r_err   <= 1'b1;
                  r_state <= StResp;
               end else if (wbm_ack_i) begin
                  r_fetch[63:32] <= wbm_dat_i;
                  r_cyc          <= 1'b0;
                  r_buf_tag      <= r_req_tag;
                  r_buf_data     <= {wbm_dat_i, r_fetch[31:0]};
                  // Any flush during this fetch leaves the entry invalid.
                  if (BUF_EN && !flush && !r_flush_pend) begin
                     r_buf_valid <= 1'b1;
                  end
                  r_state <= StResp;
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end
            StResp: begin
               r_hm_ack  <= 1'b1;
               r_hm_err  <= r_err;
               r_hm_data <= r_err ? 64'd0 : r_fetch;
               r_state   <= StIdle;
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign hm_data   = r_hm_data;
   assign hm_ack    = r_hm_ack;
   assign hm_err    = r_hm_err;
   assign wbm_adr_o = r_adr;
   assign wbm_cyc_o = r_cyc;
   assign wbm_stb_o = r_cyc;
   assign wbm_sel_o = 4'hF;
   assign wbm_we_o  = 1'b0;

endmodule

// File: tb/tb_mpu_hm_responder.sv
// Directed self-checking bench for mpu_hm_responder with a Wishbone slave model.
module tb_mpu_hm_responder;

   logic        sys_clk;
   logic        sys_rst;
   logic        hm_stb;
   logic [63:0] hm_addr;
   logic [63:0] hm_data;
   logic        hm_ack;
   logic        hm_err;
   logic        flush;
   logic [31:0] wbm_adr_o;
   logic [31:0] wbm_dat_i;
   logic [3:0]  wbm_sel_o;
   logic        wbm_cyc_o;
   logic        wbm_stb_o;
   logic        wbm_we_o;
   logic        wbm_ack_i;
   logic        wbm_err_i;

   // 0 = zero-wait ack, 1 = ack+err on high beat, 2 = never ack, 3 = ack low beat only
   logic [1:0]  slv_mode;

   int err_cnt;
   int chk_cnt;

   mpu_hm_responder #(
      .TIMEOUT(16),
      .BUF_EN (1'b1)
   ) dut (
      .sys_clk  (sys_clk),
      .sys_rst  (sys_rst),
      .hm_stb   (hm_stb),
      .hm_addr  (hm_addr),
      .hm_data  (hm_data),
      .hm_ack   (hm_ack),
      .hm_err   (hm_err),
      .flush    (flush),
      .wbm_adr_o(wbm_adr_o),
      .wbm_dat_i(wbm_dat_i),
      .wbm_sel_o(wbm_sel_o),
      .wbm_cyc_o(wbm_cyc_o),
      .wbm_stb_o(wbm_stb_o),
      .wbm_we_o (wbm_we_o),
      .wbm_ack_i(wbm_ack_i),
      .wbm_err_i(wbm_err_i)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0000_1008) return 32'hDEAD_BEEF;
      if (a == 32'h0000_100C) return 32'h0123_4567;
      return a ^ 32'hC0DE_0000;
   endfunction

   // Combinational slave
   always_comb begin
      wbm_ack_i = 1'b0;
      wbm_err_i = 1'b0;
      wbm_dat_i = 32'h0;
      if (wbm_cyc_o && wbm_stb_o) begin
         wbm_dat_i = mem_word(wbm_adr_o);
         case (slv_mode)
            2'd0: wbm_ack_i = 1'b1;
            2'd1: begin
               wbm_ack_i = 1'b1;
               wbm_err_i = wbm_adr_o[2];
            end
            2'd3: wbm_ack_i = !wbm_adr_o[2];
            default: ;
         endcase
      end
   end

   // Issue one request; lat counts posedges from driving hm_stb to seeing hm_ack.
   task automatic do_req(input logic [63:0] addr, input int flush_at,
                         output logic [63:0] data, output logic err, output int lat,
                         output int ncyc, output int nbeats,
                         output logic [31:0] a0, output logic [31:0] a1);
      bit done;
      data = '0; err = 1'b0; lat = 0; ncyc = 0; nbeats = 0; a0 = '0; a1 = '0;
      done = 1'b0;
      hm_addr = addr;
      hm_stb  = 1'b1;
      for (int i = 0; i < 100 && !done; i++) begin
         @(posedge sys_clk);
         #1;
         lat++;
         flush = (lat == flush_at);
         if (wbm_cyc_o) ncyc++;
         if (wbm_cyc_o && wbm_stb_o && (wbm_ack_i || wbm_err_i)) begin
            if (nbeats == 0) a0 = wbm_adr_o;
            if (nbeats == 1) a1 = wbm_adr_o;
            nbeats++;
         end
         if (hm_ack) begin
            data = hm_data;
            err  = hm_err;
            done = 1'b1;
         end
      end
      hm_stb = 1'b0;
      flush  = 1'b0;
      chk_cnt++;
      if (!done) begin
         err_cnt++;
         $display("FAIL req_timeout addr=%h: no hm_ack within 100 cycles", addr);
      end
   endtask

   task automatic pulse_flush();
      flush = 1'b1;
      @(posedge sys_clk);
      #1;
      flush = 1'b0;
   endtask

   task automatic test_reset();
      sys_rst = 1'b1;
      #2;
      sys_rst = 1'b0;
      repeat (2) @(posedge sys_clk);
      #1;
      chk_cnt++;
      if ({hm_ack, hm_err, wbm_cyc_o, wbm_stb_o, wbm_we_o} !== 5'b0) begin
         err_cnt++;
         $display("FAIL reset_ctrl got=%b want=00000",
                  {hm_ack, hm_err, wbm_cyc_o, wbm_stb_o, wbm_we_o});
      end
      chk_cnt++;
      if (hm_data !== 64'd0) begin
         err_cnt++;
         $display("FAIL reset_data got=%h want=0", hm_data);
      end
      chk_cnt++;
      if (wbm_adr_o !== 32'd0 || wbm_sel_o !== 4'hF) begin
         err_cnt++;
         $display("FAIL reset_adr_sel got=%h/%h want=0/f", wbm_adr_o, wbm_sel_o);
      end
      @(negedge sys_clk);
      sys_rst = 1'b1;
      @(posedge sys_clk);
      #1;
   endtask

   task automatic test_miss_hit();
      logic [63:0] d; logic e; int lat, nc, nb; logic [31:0] a0, a1;
      do_req(64'h1008, 0, d, e, lat, nc, nb, a0, a1);
      chk_cnt++;
      if (d !== 64'h0123_4567_DEAD_BEEF || e !== 1'b0) begin
         err_cnt++;
         $display("FAIL miss_data got=%h err=%b want=0123456_7deadbeef err=0", d, e);
      end
      chk_cnt++;
      if (lat != 4) begin
         err_cnt++;
         $display("FAIL miss_latency got=%0d want=4", lat);
      end
      chk_cnt++;
      if (nb != 2 || a0 !== 32'h1008 || a1 !== 32'h100C) begin
         err_cnt++;
         $display("FAIL miss_addrs got=%0d:%h,%h want=2:1008,100c", nb, a0, a1);
      end
      do_req(64'h1008, 0, d, e, lat, nc, nb, a0, a1);
      chk_cnt++;
      if (nc != 0 || lat != 2) begin
         err_cnt++;
         $display("FAIL hit_nobus got cyc=%0d lat=%0d want cyc=0 lat=2", nc, lat);
      end
      chk_cnt++;
      if (d !== 64'h0123_4567_DEAD_BEEF || e !== 1'b0) begin
         err_cnt++;
         $display("FAIL hit_data got=%h err=%b want=01234567deadbeef err=0", d, e);
      end
      pulse_flush();
      do_req(64'h1008, 0, d, e, lat, nc, nb, a0, a1);
      chk_cnt++;
      if (nb != 2 || lat != 4 || d !== 64'h0123_4567_DEAD_BEEF) begin
         err_cnt++;
         $display("FAIL flush_refetch got beats=%0d lat=%0d d=%h want 2/4/01234567deadbeef",
                  nb, lat, d);
      end
   endtask

   task automatic test_high_addr();
      logic [63:0] d; logic e; int lat, nc, nb; logic [31:0] a0, a1;
      do_req(64'h1_0000_000F, 0, d, e, lat, nc, nb, a0, a1);
      chk_cnt++;
      if (e !== 1'b1 || d !== 64'd0 || nc != 0) begin
         err_cnt++;
         $display("FAIL high_addr got err=%b d=%h cyc=%0d want err=1 d=0 cyc=0", e, d, nc);
      end
      pulse_flush();
      do_req(64'h100F, 0, d, e, lat, nc, nb, a0, a1);
      chk_cnt++;
      if (nb != 2 || a0 !== 32'h1008 || a1 !== 32'h100C || d !== 64'h0123_4567_DEAD_BEEF) begin
         err_cnt++;
         $display("FAIL unaligned got=%0d:%h,%h d=%h want=2:1008,100c d=01234567deadbeef",
                  nb, a0, a1, d);
      end
   endtask

   task automatic test_bus_err();
      logic [63:0] d; logic e; int lat, nc, nb; logic [31:0] a0, a1;
      slv_mode = 2'd1;
      do_req(64'h2000, 0, d, e, lat, nc, nb, a0, a1);
      chk_cnt++;
      if (e !== 1'b1 || d !== 64'd0) begin
         err_cnt++;
         $display("FAIL bus_err_resp got err=%b d=%h want err=1 d=0", e, d);
      end
      chk_cnt++;
      if (nc != 2 || wbm_cyc_o !== 1'b0 || a1 !== 32'h2004) begin
         err_cnt++;
         $display("FAIL bus_err_cyc got cyc_cnt=%0d cyc=%b a1=%h want 2/0/2004",
                  nc, wbm_cyc_o, a1);
      end
      slv_mode = 2'd0;
      do_req(64'h1008, 0, d, e, lat, nc, nb, a0, a1);
      chk_cnt++;
      if (nc != 0 || d !== 64'h0123_4567_DEAD_BEEF) begin
         err_cnt++;
         $display("FAIL bus_err_buf_kept got cyc=%0d d=%h want 0/01234567deadbeef", nc, d);
      end
      do_req(64'h2000, 0, d, e, lat, nc, nb, a0, a1);
      chk_cnt++;
      if (nb != 2 || e !== 1'b0 || d !== 64'hC0DE_2004_C0DE_2000) begin
         err_cnt++;
         $display("FAIL bus_err_refetch got beats=%0d err=%b d=%h want 2/0/c0de2004c0de2000",
                  nb, e, d);
      end
   endtask

   task automatic test_timeout();
      logic [63:0] d; logic e; int lat, nc, nb; logic [31:0] a0, a1;
      slv_mode = 2'd2;
      do_req(64'h3000, 0, d, e, lat, nc, nb, a0, a1);
      slv_mode = 2'd0;
      chk_cnt++;
      if (e !== 1'b1 || d !== 64'd0) begin
         err_cnt++;
         $display("FAIL timeout_resp got err=%b d=%h want err=1 d=0", e, d);
      end
      chk_cnt++;
      if (nc != 16 || lat != 18) begin
         err_cnt++;
         $display("FAIL timeout_len got cyc=%0d lat=%0d want cyc=16 lat=18", nc, lat);
      end
   endtask

   task automatic test_flush_inflight();
      logic [63:0] d; logic e; int lat, nc, nb; logic [31:0] a0, a1;
      do_req(64'h4000, 1, d, e, lat, nc, nb, a0, a1);
      chk_cnt++;
      if (d !== 64'hC0DE_4004_C0DE_4000 || e !== 1'b0) begin
         err_cnt++;
         $display("FAIL flush_lo_data got=%h err=%b want=c0de4004c0de4000 err=0", d, e);
      end
      do_req(64'h4000, 0, d, e, lat, nc, nb, a0, a1);
      chk_cnt++;
      if (nb != 2) begin
         err_cnt++;
         $display("FAIL flush_lo_novalid got beats=%0d want=2", nb);
      end
      do_req(64'h4008, 2, d, e, lat, nc, nb, a0, a1);
      do_req(64'h4008, 0, d, e, lat, nc, nb, a0, a1);
      chk_cnt++;
      if (nb != 2) begin
         err_cnt++;
         $display("FAIL flush_hi_novalid got beats=%0d want=2", nb);
      end
      do_req(64'h4008, 0, d, e, lat, nc, nb, a0, a1);
      chk_cnt++;
      if (nc != 0 || d !== 64'hC0DE_400C_C0DE_4008) begin
         err_cnt++;
         $display("FAIL flush_then_hit got cyc=%0d d=%h want 0/c0de400cc0de4008", nc, d);
      end
   endtask

   task automatic test_reset_mid();
      logic [63:0] d; logic e; int lat, nc, nb; logic [31:0] a0, a1;
      int acks;
      do_req(64'h5000, 0, d, e, lat, nc, nb, a0, a1);
      slv_mode = 2'd3;
      hm_addr  = 64'h5008;
      hm_stb   = 1'b1;
      repeat (2) @(posedge sys_clk);
      #1;
      chk_cnt++;
      if (wbm_cyc_o !== 1'b1 || wbm_adr_o !== 32'h500C) begin
         err_cnt++;
         $display("FAIL mid_rdhi got cyc=%b adr=%h want 1/500c", wbm_cyc_o, wbm_adr_o);
      end
      #2;
      sys_rst = 1'b0;
      #1;
      chk_cnt++;
      if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0) begin
         err_cnt++;
         $display("FAIL mid_async_drop got cyc=%b stb=%b want 0/0", wbm_cyc_o, wbm_stb_o);
      end
      acks = 0;
      repeat (3) begin
         @(posedge sys_clk);
         #1;
         if (hm_ack) acks++;
      end
      hm_stb   = 1'b0;
      slv_mode = 2'd0;
      @(negedge sys_clk);
      sys_rst = 1'b1;
      repeat (2) begin
         @(posedge sys_clk);
         #1;
         if (hm_ack) acks++;
      end
      chk_cnt++;
      if (acks != 0) begin
         err_cnt++;
         $display("FAIL mid_no_ack got=%0d want=0", acks);
      end
      do_req(64'h5000, 0, d, e, lat, nc, nb, a0, a1);
      chk_cnt++;
      if (nb != 2 || d !== 64'hC0DE_5004_C0DE_5000) begin
         err_cnt++;
         $display("FAIL mid_buf_invalid got beats=%0d d=%h want 2/c0de5004c0de5000", nb, d);
      end
   endtask

   initial begin
      err_cnt  = 0;
      chk_cnt  = 0;
      slv_mode = 2'd0;
      hm_stb   = 1'b0;
      hm_addr  = '0;
      flush    = 1'b0;
      test_reset();
      test_miss_hit();
      test_high_addr();
      test_bus_err();
      test_timeout();
      test_flush_inflight();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
